// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage with a single branch delay slot.
//   Holds the fetch PC, the F/D pipeline register and a running count of
//   instructions committed into F/D. Redirects come from the control
//   transfer currently in D and take effect on the next unstalled edge.
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   stall             hold PC, F/D register and fetch counter
//   npc_op            next-PC select for the instruction in D
//   cmp_zero          D-stage comparator "equal"
//   cmp_overflow      D-stage comparator signed-add overflow
//   d_imm16, d_imm26  branch offset / jump index of the instruction in D
//   d_rs_val          forwarded rs value (JR target)
//   im_instr          instruction memory data for pc_f
//   pc_f              fetch address
//   instr_d, pc_d     F/D register contents
//   taken_d           combinational: D-stage transfer taken
//   fetch_cnt         instructions committed into F/D since reset
module fetch_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [2:0]  npc_op,
  input  logic        cmp_zero,
  input  logic        cmp_overflow,
  input  logic [15:0] d_imm16,
  input  logic [25:0] d_imm26,
  input  logic [31:0] d_rs_val,
  input  logic [31:0] im_instr,
  output logic [31:0] pc_f,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic        taken_d,
  output logic [31:0] fetch_cnt
);

  localparam int unsigned XLEN     = 32;
  localparam int unsigned IMM16_W  = 16;
  localparam int unsigned SEXT_W   = XLEN - IMM16_W - 2;
  localparam logic [XLEN-1:0] RESET_PC = 32'h0000_3000;
  localparam logic [XLEN-1:0] INSTR_BYTES = 32'd4;

  localparam logic [2:0] NPC_SEQ   = 3'd0;
  localparam logic [2:0] NPC_BEQ   = 3'd1;
  localparam logic [2:0] NPC_BIOAL = 3'd2;
  localparam logic [2:0] NPC_J     = 3'd3;
  localparam logic [2:0] NPC_JR    = 3'd4;

  logic [XLEN-1:0] seq_pc;
  logic [XLEN-1:0] br_target;
  logic [XLEN-1:0] j_target;
  logic [XLEN-1:0] redirect_pc;
  logic [XLEN-1:0] next_pc;

  // Candidate next-PC values; all arithmetic is modulo 2^32.
  always_comb begin
    seq_pc    = pc_f + INSTR_BYTES;
    br_target = pc_d + INSTR_BYTES
              + {{SEXT_W{d_imm16[IMM16_W-1]}}, d_imm16, 2'b00};
    j_target  = {pc_d[31:28], d_imm26, 2'b00};
  end

  // Taken decision and target select for the transfer sitting in D.
  // Codes 5-7 fall through to sequential.
  always_comb begin
    taken_d     = 1'b0;
    redirect_pc = seq_pc;
    case (npc_op)
      NPC_SEQ: begin
        taken_d     = 1'b0;
        redirect_pc = seq_pc;
      end
      NPC_BEQ: begin
        taken_d     = cmp_zero;
        redirect_pc = br_target;
      end
      NPC_BIOAL: begin
        taken_d     = cmp_overflow;
        redirect_pc = br_target;
      end
      NPC_J: begin
        taken_d     = 1'b1;
        redirect_pc = j_target;
      end
      NPC_JR: begin
        taken_d     = 1'b1;
        redirect_pc = d_rs_val;
      end
      default: begin
        taken_d     = 1'b0;
        redirect_pc = seq_pc;
      end
    endcase
  end

  always_comb begin
    next_pc = taken_d ? redirect_pc : seq_pc;
  end

  // PC, F/D register and counter; stall freezes everything, so a stalled
  // transfer is simply re-evaluated with fresh compare inputs next cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_f      <= RESET_PC;
      instr_d   <= '0;
      pc_d      <= '0;
      fetch_cnt <= '0;
    end else if (!stall) begin
      pc_f      <= next_pc;
      instr_d   <= im_instr;
      pc_d      <= pc_f;
      fetch_cnt <= fetch_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized
// run against a transaction-level model of the fetch stage.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic [2:0]  npc_op;
  logic        cmp_zero;
  logic        cmp_overflow;
  logic [15:0] d_imm16;
  logic [25:0] d_imm26;
  logic [31:0] d_rs_val;
  logic [31:0] im_instr;
  logic [31:0] pc_f;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic        taken_d;
  logic [31:0] fetch_cnt;

  int checks = 0;
  int errors = 0;

  // Model state
  logic [31:0] m_pc_f, m_instr_d, m_pc_d, m_cnt;

  fetch_unit dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .npc_op       (npc_op),
    .cmp_zero     (cmp_zero),
    .cmp_overflow (cmp_overflow),
    .d_imm16      (d_imm16),
    .d_imm26      (d_imm26),
    .d_rs_val     (d_rs_val),
    .im_instr     (im_instr),
    .pc_f         (pc_f),
    .instr_d      (instr_d),
    .pc_d         (pc_d),
    .taken_d      (taken_d),
    .fetch_cnt    (fetch_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic model_taken();
    if (npc_op == 3'd1) return cmp_zero;
    if (npc_op == 3'd2) return cmp_overflow;
    if (npc_op == 3'd3 || npc_op == 3'd4) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_target();
    int off;
    off = int'($signed(d_imm16)) * 4;
    case (npc_op)
      3'd1, 3'd2: return m_pc_d + 32'd4 + 32'(off);
      3'd3:       return (m_pc_d & 32'hF000_0000) + 32'(d_imm26) * 32'd4;
      3'd4:       return d_rs_val;
      default:    return m_pc_f + 32'd4;
    endcase
  endfunction

  task automatic model_reset();
    m_pc_f    = 32'h0000_3000;
    m_instr_d = 32'h0;
    m_pc_d    = 32'h0;
    m_cnt     = 32'h0;
  endtask

  task automatic drive(input logic [2:0] op, input logic z, input logic o,
                       input logic [15:0] i16, input logic [25:0] i26,
                       input logic [31:0] rs);
    npc_op       = op;
    cmp_zero     = z;
    cmp_overflow = o;
    d_imm16      = i16;
    d_imm26      = i26;
    d_rs_val     = rs;
    im_instr     = $urandom;
  endtask

  // One rising edge; the model advances with the inputs seen at that edge.
  task automatic tick();
    logic        t;
    logic [31:0] nxt;
    @(posedge clk);
    if (reset) begin
      model_reset();
    end else if (!stall) begin
      t   = model_taken();
      nxt = t ? model_target() : m_pc_f + 32'd4;
      m_pc_d    = m_pc_f;
      m_instr_d = im_instr;
      m_pc_f    = nxt;
      m_cnt     = m_cnt + 32'd1;
    end
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    stall = 1'b0;
    drive(3'd0, 1'b0, 1'b0, 16'h0, 26'h0, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    stall = 1'b0;
    drive(3'd0, 1'b0, 1'b0, 16'h0, 26'h0, 32'h0);
    model_reset();
    #2;
    checks++; if (pc_f !== 32'h3000) begin errors++; $display("FAIL reset_pc_f got %h exp %h", pc_f, 32'h3000); end
    checks++; if (instr_d !== 32'h0) begin errors++; $display("FAIL reset_instr_d got %h exp 0", instr_d); end
    checks++; if (pc_d !== 32'h0) begin errors++; $display("FAIL reset_pc_d got %h exp 0", pc_d); end
    checks++; if (fetch_cnt !== 32'h0) begin errors++; $display("FAIL reset_cnt got %h exp 0", fetch_cnt); end
    tick();
    checks++; if (pc_f !== 32'h3000 || fetch_cnt !== 32'h0) begin errors++; $display("FAIL reset_hold pc_f %h cnt %h exp 3000/0", pc_f, fetch_cnt); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc [3];
    exp_pc[0] = 32'h3004; exp_pc[1] = 32'h3008; exp_pc[2] = 32'h300C;
    for (int i = 0; i < 3; i++) begin
      drive(3'd0, 1'b0, 1'b0, 16'h0, 26'h0, 32'h0);
      tick();
      checks++; if (pc_f !== exp_pc[i]) begin errors++; $display("FAIL seq_pc_f[%0d] got %h exp %h", i, pc_f, exp_pc[i]); end
      checks++; if (instr_d !== m_instr_d) begin errors++; $display("FAIL seq_instr_d[%0d] got %h exp %h", i, instr_d, m_instr_d); end
    end
    checks++; if (pc_d !== 32'h3008) begin errors++; $display("FAIL seq_pc_d got %h exp 3008", pc_d); end
    checks++; if (fetch_cnt !== 32'd3) begin errors++; $display("FAIL seq_cnt got %0d exp 3", fetch_cnt); end
  endtask

  task automatic test_beq();
    logic [31:0] prev;
    do_reset();
    repeat (2) begin drive(3'd0, 1'b0, 1'b0, 16'h0, 26'h0, 32'h0); tick(); end
    checks++; if (pc_d !== 32'h3004) begin errors++; $display("FAIL beq_setup pc_d got %h exp 3004", pc_d); end
    drive(3'd1, 1'b1, 1'b0, 16'hFFFF, 26'h0, 32'h0);
    #1;
    checks++; if (taken_d !== 1'b1) begin errors++; $display("FAIL beq_taken got %b exp 1", taken_d); end
    tick();
    checks++; if (pc_f !== 32'h3004) begin errors++; $display("FAIL beq_target got %h exp 3004", pc_f); end
    drive(3'd1, 1'b0, 1'b1, 16'hFFFF, 26'h0, 32'h0);
    prev = pc_f;
    #1;
    checks++; if (taken_d !== 1'b0) begin errors++; $display("FAIL beq_not_taken got %b exp 0", taken_d); end
    tick();
    checks++; if (pc_f !== prev + 32'd4) begin errors++; $display("FAIL beq_fallthru got %h exp %h", pc_f, prev + 32'd4); end
  endtask

  task automatic test_bioal();
    do_reset();
    repeat (5) begin drive(3'd0, 1'b0, 1'b0, 16'h0, 26'h0, 32'h0); tick(); end
    checks++; if (pc_d !== 32'h3010) begin errors++; $display("FAIL bioal_setup pc_d got %h exp 3010", pc_d); end
    drive(3'd2, 1'b0, 1'b1, 16'h0010, 26'h0, 32'h0);
    tick();
    checks++; if (pc_f !== 32'h3054) begin errors++; $display("FAIL bioal_target got %h exp 3054", pc_f); end
    drive(3'd2, 1'b1, 1'b0, 16'h0010, 26'h0, 32'h0);
    #1;
    checks++; if (taken_d !== 1'b0) begin errors++; $display("FAIL bioal_not_taken got %b exp 0", taken_d); end
    tick();
    checks++; if (pc_f !== 32'h3058) begin errors++; $display("FAIL bioal_fallthru got %h exp 3058", pc_f); end
  endtask

  task automatic test_jumps();
    do_reset();
    repeat (9) begin drive(3'd0, 1'b0, 1'b0, 16'h0, 26'h0, 32'h0); tick(); end
    checks++; if (pc_d !== 32'h3020) begin errors++; $display("FAIL j_setup pc_d got %h exp 3020", pc_d); end
    drive(3'd3, 1'b0, 1'b0, 16'h0, 26'h0000C40, 32'h0);
    tick();
    checks++; if (pc_f !== 32'h3100) begin errors++; $display("FAIL j_target got %h exp 3100", pc_f); end
    drive(3'd4, 1'b0, 1'b0, 16'h0, 26'h0, 32'h0000_3402);
    tick();
    checks++; if (pc_f !== 32'h3402) begin errors++; $display("FAIL jr_target got %h exp 3402", pc_f); end
    drive(3'd4, 1'b0, 1'b0, 16'h0, 26'h0, 32'hFFFF_FFFC);
    tick();
    checks++; if (pc_f !== 32'hFFFF_FFFC) begin errors++; $display("FAIL jr_high got %h exp fffffffc", pc_f); end
    drive(3'd0, 1'b0, 1'b0, 16'h0, 26'h0, 32'h0);
    tick();
    checks++; if (pc_f !== 32'h0) begin errors++; $display("FAIL pc_wrap got %h exp 0", pc_f); end
    for (int op = 5; op < 8; op++) begin
      drive(3'(op), 1'b1, 1'b1, 16'h1234, 26'h3FF_FFFF, 32'hDEAD_BEEF);
      #1;
      checks++; if (taken_d !== 1'b0) begin errors++; $display("FAIL op%0d_taken got %b exp 0", op, taken_d); end
    end
  endtask

  task automatic test_stall();
    logic [31:0] s_pc_f, s_instr_d, s_pc_d, s_cnt;
    logic [25:0] idx;
    do_reset();
    repeat (3) begin drive(3'd0, 1'b0, 1'b0, 16'h0, 26'h0, 32'h0); tick(); end
    s_pc_f = pc_f; s_instr_d = instr_d; s_pc_d = pc_d; s_cnt = fetch_cnt;
    idx = 26'($urandom);
    drive(3'd3, 1'b0, 1'b0, 16'h0, idx, 32'h0);
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if (taken_d !== 1'b1) begin errors++; $display("FAIL stall_taken[%0d] got %b exp 1", i, taken_d); end
      im_instr = $urandom;
      tick();
      checks++;
      if (pc_f !== s_pc_f || instr_d !== s_instr_d || pc_d !== s_pc_d || fetch_cnt !== s_cnt) begin
        errors++;
        $display("FAIL stall_hold[%0d] got pc_f %h instr_d %h pc_d %h cnt %0d exp %h %h %h %0d",
                 i, pc_f, instr_d, pc_d, fetch_cnt, s_pc_f, s_instr_d, s_pc_d, s_cnt);
      end
    end
    stall = 1'b0;
    tick();
    checks++; if (pc_f !== ((s_pc_d & 32'hF000_0000) | (32'(idx) << 2))) begin
      errors++; $display("FAIL stall_release_jump got %h exp %h", pc_f, (s_pc_d & 32'hF000_0000) | (32'(idx) << 2));
    end
    checks++; if (fetch_cnt !== s_cnt + 32'd1) begin errors++; $display("FAIL stall_release_cnt got %0d exp %0d", fetch_cnt, s_cnt + 32'd1); end
  endtask

  task automatic test_async_reset();
    do_reset();
    repeat (2) begin drive(3'd0, 1'b0, 1'b0, 16'h0, 26'h0, 32'h0); tick(); end
    drive(3'd1, 1'b1, 1'b0, 16'h0100, 26'h0, 32'h0);
    stall = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (pc_f !== 32'h3000 || instr_d !== 32'h0 || pc_d !== 32'h0 || fetch_cnt !== 32'h0) begin
      errors++;
      $display("FAIL async_reset got pc_f %h instr_d %h pc_d %h cnt %0d exp 3000 0 0 0", pc_f, instr_d, pc_d, fetch_cnt);
    end
    #2;
    reset = 1'b0;
    stall = 1'b0;
    model_reset();
    drive(3'd0, 1'b0, 1'b0, 16'h0, 26'h0, 32'h0);
    #1;
    checks++; if (pc_f !== 32'h3000) begin errors++; $display("FAIL async_release_pc_f got %h exp 3000", pc_f); end
    tick();
    checks++; if (pc_f !== 32'h3004 || pc_d !== 32'h3000 || fetch_cnt !== 32'd1) begin
      errors++; $display("FAIL async_first_fetch got pc_f %h pc_d %h cnt %0d exp 3004 3000 1", pc_f, pc_d, fetch_cnt);
    end
  endtask

  task automatic test_random();
    logic exp_t;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      drive(3'($urandom_range(0, 7)), 1'($urandom), 1'($urandom),
            16'($urandom), 26'($urandom), $urandom);
      stall = ($urandom_range(0, 3) == 0);
      #1;
      exp_t = model_taken();
      checks++; if (taken_d !== exp_t) begin errors++; $display("FAIL rnd_taken[%0d] op %0d got %b exp %b", i, npc_op, taken_d, exp_t); end
      tick();
      checks++;
      if (pc_f !== m_pc_f || instr_d !== m_instr_d || pc_d !== m_pc_d || fetch_cnt !== m_cnt) begin
        errors++;
        $display("FAIL rnd_state[%0d] got pc_f %h instr_d %h pc_d %h cnt %0d exp %h %h %h %0d",
                 i, pc_f, instr_d, pc_d, fetch_cnt, m_pc_f, m_instr_d, m_pc_d, m_cnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_beq();
    test_bioal();
    test_jumps();
    test_stall();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
